// File: rtl/mem_latency_responder.sv
// Fixed-latency word memory responder for a CPU data port: accepts one read or write,
// stalls the requester for LATENCY cycles, then pulses ready with the access complete.
module mem_latency_responder #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned DEPTH   = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        readM,
    input  logic        writeM,
    input  logic [15:0] address,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        ready,
    output logic        protocol_err
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit          SkipWait = (LATENCY == 1);
    localparam logic [3:0]  CntLoad  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    if (LATENCY < 1 || LATENCY > 15) begin : gen_bad_latency
        $error("mem_latency_responder: LATENCY must be within 1..15");
    end
    if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 2 || DEPTH > 65536) begin : gen_bad_depth
        $error("mem_latency_responder: DEPTH must be a power of two in 2..65536");
    end

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            op_wr_q, op_wr_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            perr_q, perr_d;

    logic [15:0]     mem_q [DEPTH];

    logic            req;
    logic            access;
    logic [AW-1:0]   acc_idx;
    logic [15:0]     acc_wdata;
    logic            acc_wr;

    assign req = readM | writeM;

    // Upper address bits alias onto the same storage and are intentionally dropped.
    if (AW < 16) begin : gen_alias
        logic unused_addr_bits;
        assign unused_addr_bits = ^address[15:AW];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        perr_d    = perr_q;
        busy      = 1'b0;
        access    = 1'b0;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_wr    = op_wr_q;

        case (state_q)
            StIdle: begin
                if (req) begin
                    busy    = 1'b1;
                    idx_d   = address[AW-1:0];
                    wdata_d = wdata;
                    op_wr_d = writeM;
                    perr_d  = perr_q | (readM & writeM);
                    if (SkipWait) begin
                        // Single-cycle latency completes on this edge from the live inputs.
                        state_d   = StDone;
                        access    = 1'b1;
                        acc_idx   = address[AW-1:0];
                        acc_wdata = wdata;
                        acc_wr    = writeM;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = StDone;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        rdata_d = (access && !acc_wr) ? mem_q[acc_idx] : rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 16'h0000;
            op_wr_q <= 1'b0;
            rdata_q <= 16'h0000;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_wr_q <= op_wr_d;
            rdata_q <= rdata_d;
            perr_q  <= perr_d;
        end
    end

    // Storage survives reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && access && acc_wr) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign rdata        = rdata_q;
    assign ready        = (state_q == StDone);
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed bench: LATENCY=2 instance covers function/reset; LATENCY=1 and 15 cover latency bounds.
module tb_mem_latency_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] address;
    logic [15:0] wdata;
    logic [2:0]  rd_v;
    logic [2:0]  wr_v;
    logic [15:0] rdata_v [3];
    logic [2:0]  busy_v;
    logic [2:0]  ready_v;
    logic [2:0]  perr_v;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int ready_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (ready_v[0]) ready_cnt <= ready_cnt + 1;

    mem_latency_responder #(.LATENCY(2), .DEPTH(256)) u_dut (
        .clk(clk), .reset_n(reset_n), .readM(rd_v[0]), .writeM(wr_v[0]),
        .address(address), .wdata(wdata), .rdata(rdata_v[0]), .busy(busy_v[0]),
        .ready(ready_v[0]), .protocol_err(perr_v[0])
    );

    mem_latency_responder #(.LATENCY(1), .DEPTH(256)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .readM(rd_v[1]), .writeM(wr_v[1]),
        .address(address), .wdata(wdata), .rdata(rdata_v[1]), .busy(busy_v[1]),
        .ready(ready_v[1]), .protocol_err(perr_v[1])
    );

    mem_latency_responder #(.LATENCY(15), .DEPTH(256)) u_dut_l15 (
        .clk(clk), .reset_n(reset_n), .readM(rd_v[2]), .writeM(wr_v[2]),
        .address(address), .wdata(wdata), .rdata(rdata_v[2]), .busy(busy_v[2]),
        .ready(ready_v[2]), .protocol_err(perr_v[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after a rising edge; request held until the ready cycle has passed.
    task automatic access(input int sel, input logic wr, input logic rd,
                          input logic [15:0] a, input logic [15:0] d, input bit scramble,
                          output int lat, output int nbusy, output logic [15:0] rval,
                          output int t_ready);
        address = a;
        wdata   = d;
        wr_v[sel] = wr;
        rd_v[sel] = rd;
        lat = -1;
        nbusy = 0;
        rval = 16'h0;
        t_ready = -1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            @(negedge clk);
            if (busy_v[sel]) nbusy++;
            if (ready_v[sel]) begin
                lat = c;
                rval = rdata_v[sel];
                t_ready = cyc;
            end
            @(posedge clk);
            #1;
            if (scramble && c == 0 && lat < 0) begin
                address = ~a;
                wdata = ~d;
                wr_v[sel] = rd;
                rd_v[sel] = wr;
            end
        end
        wr_v[sel] = 1'b0;
        rd_v[sel] = 1'b0;
    endtask

    task automatic do_write(input int sel, input logic [15:0] a, input logic [15:0] d,
                            input int exp_lat, input string tag);
        int lat, nbusy, t;
        logic [15:0] v;
        access(sel, 1'b1, 1'b0, a, d, 1'b0, lat, nbusy, v, t);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, nbusy, exp_lat);
    endtask

    task automatic do_read(input int sel, input logic [15:0] a, input logic [15:0] exp_d,
                           input int exp_lat, input string tag);
        int lat, nbusy, t;
        logic [15:0] v;
        access(sel, 1'b0, 1'b1, a, 16'h0, 1'b0, lat, nbusy, v, t);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_data"}, v, exp_d);
    endtask

    initial begin
        int lat, nbusy, t1, t2, rc;
        logic [15:0] v1, v2;

        reset_n = 1'b0;
        rd_v = '0;
        wr_v = '0;
        address = '0;
        wdata = '0;
        #2;
        check("rst_rdata", rdata_v[0], 16'h0);
        check("rst_ready", ready_v[0], 1'b0);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_perr", perr_v[0], 1'b0);
        rd_v[0] = 1'b1;
        #1;
        check("rst_busy_with_req", busy_v[0], 1'b1);
        rd_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // First edge after reset release accepts immediately.
        do_write(0, 16'h0010, 16'hBEEF, 2, "w_beef");
        do_read(0, 16'h0010, 16'hBEEF, 2, "r_beef");

        do_write(0, 16'h0001, 16'h0A01, 2, "w_1");
        do_write(0, 16'h0002, 16'h0B02, 2, "w_2");
        rc = ready_cnt;
        access(0, 1'b0, 1'b1, 16'h0001, 16'h0, 1'b0, lat, nbusy, v1, t1);
        access(0, 1'b0, 1'b1, 16'h0002, 16'h0, 1'b0, lat, nbusy, v2, t2);
        check("b2b_data1", v1, 16'h0A01);
        check("b2b_data2", v2, 16'h0B02);
        check("b2b_spacing", t2 - t1, 3);
        @(posedge clk);
        #1;
        check("b2b_ready_count", ready_cnt - rc, 2);
        check("b2b_idle_busy", busy_v[0], 1'b0);

        do_write(0, 16'h0105, 16'h1234, 2, "w_alias");
        do_read(0, 16'h0005, 16'h1234, 2, "r_alias");

        // Inputs scrambled during WAIT must not redirect the pending write.
        do_write(0, 16'h00BF, 16'h7777, 2, "w_bf");
        access(0, 1'b1, 1'b0, 16'h0040, 16'hC0DE, 1'b1, lat, nbusy, v1, t1);
        check("scr_lat", lat, 2);
        do_read(0, 16'h0040, 16'hC0DE, 2, "r_scr");
        do_read(0, 16'h00BF, 16'h7777, 2, "r_scr_other");
        repeat (3) @(posedge clk);
        #1;
        check("rdata_hold", rdata_v[0], 16'h7777);

        check("perr_before", perr_v[0], 1'b0);
        access(0, 1'b1, 1'b1, 16'h0020, 16'h00AA, 1'b0, lat, nbusy, v1, t1);
        check("both_lat", lat, 2);
        check("perr_set", perr_v[0], 1'b1);
        do_read(0, 16'h0020, 16'h00AA, 2, "r_both");
        check("perr_sticky", perr_v[0], 1'b1);

        do_write(0, 16'h0030, 16'h1111, 2, "w_30");
        address = 16'h0030;
        wdata = 16'h5555;
        wr_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("mid_busy_wait", busy_v[0], 1'b1);
        reset_n = 1'b0;
        wr_v[0] = 1'b0;
        #1;
        check("mid_rst_rdata", rdata_v[0], 16'h0);
        check("mid_rst_ready", ready_v[0], 1'b0);
        check("mid_rst_busy", busy_v[0], 1'b0);
        check("mid_rst_perr", perr_v[0], 1'b0);
        rc = ready_cnt;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_no_ready", ready_cnt - rc, 0);
        check("mid_rdata_zero", rdata_v[0], 16'h0);
        do_read(0, 16'h0030, 16'h1111, 2, "r_30_kept");

        do_write(1, 16'h0011, 16'h3C3C, 1, "l1_w");
        do_read(1, 16'h0011, 16'h3C3C, 1, "l1_r");
        do_write(2, 16'h0022, 16'hA5A5, 15, "l15_w");
        do_read(2, 16'h0022, 16'hA5A5, 15, "l15_r");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_latency_responder.md
MEM_LATENCY_RESPONDER -- requirements
Module: mem_latency_responder

Interface
REQ-001 Parameter LATENCY, default 2, access latency in cycles from request cycle to completion cycle; legal range 1..15.
REQ-002 Parameter DEPTH, default 256, number of 16-bit words stored; power of two.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 readM  input  1  read request from CPU, held until busy is low.
REQ-006 writeM  input  1  write request from CPU, held until busy is low.
REQ-007 address  input  16  word address; low log2(DEPTH) bits index storage, upper bits ignored (aliasing).
REQ-008 wdata  input  16  write data, sampled with the request.
REQ-009 rdata  output  16  read data, registered, valid from the ready cycle onward until the next read completes.
REQ-010 busy  output  1  stall indication to the CPU pipeline (feeds memory-busy stall logic).
REQ-011 ready  output  1  one-cycle completion pulse.
REQ-012 protocol_err  output  1  sticky flag: readM and writeM seen high together at acceptance.

Function
REQ-013 The block SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE: request = readM | writeM; when set, the block SHALL latch address, wdata, op (write if writeM, else read) and go to WAIT if LATENCY>1, else to DONE; the counter loads LATENCY-2.
REQ-015 WAIT: the counter SHALL decrement each cycle; at counter==0, the block SHALL go to DONE.
REQ-016 The access SHALL be performed at the edge entering DONE: write updates storage at the latched index; read loads rdata from the latched index.
REQ-017 DONE: ready=1 for exactly that cycle; requests SHALL be ignored; the next state SHALL be IDLE unconditionally.
REQ-018 busy SHALL be combinational: busy = (IDLE & (readM|writeM)) | WAIT; busy=0 in DONE.
REQ-019 Request-cycle to ready-cycle distance SHALL equal LATENCY exactly; busy is high for exactly LATENCY consecutive cycles per access.
REQ-020 Back-to-back: a request present in the first IDLE cycle after DONE SHALL be accepted with no extra bubble.
REQ-021 readM and writeM both high at acceptance: the block SHALL perform the write only and set protocol_err.
REQ-022 Request inputs changing during WAIT SHALL NOT affect the pending access; latched values SHALL be used.
REQ-023 Read after write to the same index SHALL return the newly written value.
REQ-024 The counter SHALL be 4 bits and SHALL NOT underflow; LATENCY=1 skips WAIT entirely.

Reset
REQ-025 On reset_n low, the block SHALL asynchronously force state=IDLE, counter=0, rdata=16'h0000, ready=0, protocol_err=0.
REQ-026 busy SHALL follow REQ-018 during and after reset: it is 0 unless a request is present in IDLE.
REQ-027 Reset mid-access SHALL discard the pending access (no storage write, rdata=0).
REQ-028 Storage contents SHALL NOT be cleared by reset.
REQ-029 After reset_n rises, the first rising edge SHALL be able to accept a request.

Verification
REQ-030 LATENCY=2: writeM with address=16'h0010, wdata=16'hBEEF at cycle 0 -> busy=1 in cycles 0-1, ready=1 in cycle 2; then readM with address=16'h0010 -> rdata=16'hBEEF in its ready cycle.
REQ-031 Back-to-back reads of 16'h0001 then 16'h0002 (each held until busy=0) -> ready pulses 3 cycles apart (LATENCY=2); no request is accepted twice in DONE.
REQ-032 Aliasing, DEPTH=256: write 16'h1234 to address 16'h0105, then read 16'h0005 -> rdata=16'h1234.
REQ-033 readM=writeM=1 with address=16'h0020, wdata=16'h00AA -> write occurs and protocol_err=1 until reset; a later read of 16'h0020 -> 16'h00AA.
REQ-034 Write to 16'h0030 with 16'h5555 in progress, reset_n pulsed low in WAIT -> ready never pulses, rdata=0, and a later read of 16'h0030 returns its prior content.
REQ-035 LATENCY=1 and LATENCY=15 builds: busy high for exactly 1 and 15 cycles respectively per access.
